strb_split_mask: RTL
====================

Name: strb_split_mask

Overview:
- Parametrised successor to the fixed 8-byte strobe-to-mask converter on the AXI-to-P-Mesh write path.
- Accepts one AXI write strobe of STRB_W byte lanes per input handshake and splits it into a sequence of naturally aligned, power-of-two byte-lane masks, one per output handshake.
- Each emitted mask is directly legal as a P-Mesh store mask.
- Sits between the AXI W-channel skid buffer and the P-Mesh store packetiser; full valid/ready on both sides.

Parameters:
- STRB_W, 8: byte lanes per beat; power of two, 2..64.
- MAX_SIZE_LOG2, $clog2(STRB_W): largest emitted chunk is 2^MAX_SIZE_LOG2 bytes; range 0..$clog2(STRB_W).
- Derived, not overridable: OFF_W = $clog2(STRB_W); SZ_W = $clog2(MAX_SIZE_LOG2+1), minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_strb  in  STRB_W  AXI wstrb; bit i = byte lane i
- i_valid  in  1  input beat valid
- i_ready  out  1  input beat accepted when i_valid & i_ready
- o_mask  out  STRB_W  aligned chunk mask
- o_size  out  SZ_W  log2 of chunk size in bytes
- o_offset  out  OFF_W  lowest byte lane of chunk
- o_first  out  1  first chunk of the beat
- o_last  out  1  final chunk of the beat
- o_valid  out  1  chunk valid
- o_ready  in  1  downstream accepts chunk

Behaviour:
- Reset: asynchronous, active-high; takes effect without a clock edge.
  - Clears FSM to IDLE, rem_q to 0, first_q to 0.
  - All outputs read 0 while rst is high, including mid-split; the partially split beat is discarded.
- FSM states: IDLE, BUSY.
  - IDLE: i_ready = 1, o_valid = 0.
  - BUSY: o_valid = 1.
- Accepting a beat in IDLE:
  - i_strb != 0: rem_q <= i_strb, first_q <= 1, go to BUSY.
  - i_strb == 0: beat is consumed and dropped; stay in IDLE (see Optional Feature).
- Chunk selection (combinational from rem_q):
  - p = index of the lowest set bit of rem_q.
  - s = largest value <= MAX_SIZE_LOG2 such that p mod 2^s == 0 and all bits [p, p+2^s) of rem_q are set.
  - o_mask = ((1<<2^s)-1) << p; o_offset = p; o_size = s.
  - o_last = ((rem_q & ~o_mask) == 0); o_first = first_q.
- Chunk handshake in BUSY with o_ready = 1: rem_q <= rem_q & ~o_mask; first_q <= 0; if o_last, go to IDLE.
- Stall: while o_valid & ~o_ready, all outputs hold stable.
- Latency: first chunk is valid the cycle after input acceptance. A beat that splits into N chunks occupies N cycles when o_ready is held high.
- Back-to-back: i_ready = IDLE | (o_valid & o_ready & o_last).
  - A beat accepted in the same cycle as the last chunk loads rem_q directly, so there are no bubble cycles.
- i_valid while BUSY (not last chunk): i_ready = 0; the upstream holds i_strb per AXI rules.
- Outputs never depend combinationally on i_strb. i_ready depends combinationally on o_ready.
- Outputs are forced to 0 whenever o_valid = 0.

Optional Feature:
- Macro: STRB_SPLIT_ZERO_PASS_EN.
- Defined: an all-zero strobe is not dropped. It produces exactly one output chunk with o_mask = 0, o_size = 0, o_offset = 0, o_first = 1, o_last = 1, so every AXI beat yields at least one P-Mesh transaction.
  - Implement with a zero_q flag held in BUSY.
- Undefined: an all-zero strobe is silently consumed with no output, as described above.

Decomposition:
- Shared package strb_split_pkg:
  - state enum {IDLE, BUSY};
  - function clog2_f;
  - size encoding constants SZ_1B = 0, SZ_2B = 1, SZ_4B = 2, SZ_8B = 3;
  - function size_to_bytes.
- One combinational sub-module, strb_chunk_sel (params STRB_W, MAX_SIZE_LOG2).
  - Input: rem.
  - Outputs: mask, size, offset, last.
  - Contains the lowest-set-bit priority encoder and the per-size alignment/coverage check.
- Top level holds the FSM, rem_q, first_q and the handshake logic.

Test Plan:
- STRB_W=8, i_strb=0xFF, o_ready=1 -> one chunk next cycle: mask 0xFF, size 3, offset 0, first=1, last=1; i_ready high that same cycle.
- i_strb=0xFE -> chunks 0x02 (size 0, off 1), 0x0C (size 1, off 2), 0xF0 (size 2, off 4, last) on consecutive cycles.
- i_strb=0x3C with o_ready toggling 1,0,0,1 -> 0x0C, then 0x30 held stable through the two stall cycles, then accepted; no chunk lost or duplicated.
- MAX_SIZE_LOG2=1, i_strb=0x0F -> 0x03 then 0x0C (size 1 each); then beat 0x80 accepted on the last-chunk cycle -> 0x80 in the following cycle with no bubble.
- Assert rst asynchronously mid-split of 0x55 after the first chunk -> o_valid/outputs go 0 immediately; after release, i_ready=1 and beat 0x01 yields a single chunk 0x01.
- i_strb=0x00 -> no output without the macro; with STRB_SPLIT_ZERO_PASS_EN, one chunk mask 0x00, first=last=1.

Source files
------------

// File: rtl/strb_split_pkg.sv
// -----------------------------------------------------------------------------
// strb_split_pkg
// Purpose : shared types, constants and helper functions for the strobe
//           splitter (strb_split_mask) and its chunk selector (strb_chunk_sel).
// Contents: state_t    - splitter FSM state {IDLE, BUSY}
//           clog2_f    - constant-evaluable ceiling log2
//           SZ_*       - o_size encodings (log2 of chunk bytes)
//           size_to_bytes - converts a size encoding to a byte count
// -----------------------------------------------------------------------------
package strb_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int SZ_1B = 0;
  localparam int SZ_2B = 1;
  localparam int SZ_4B = 2;
  localparam int SZ_8B = 3;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  function automatic int size_to_bytes(input int size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/strb_chunk_sel.sv
// -----------------------------------------------------------------------------
// strb_chunk_sel
// Purpose : purely combinational selection of the next naturally aligned,
//           power-of-two chunk from the remaining strobe bits. The chunk
//           starts at the lowest set lane and is grown to the largest size
//           (up to 2^MAX_SIZE_LOG2 lanes) that is both aligned to its own size
//           and fully covered by set strobe bits.
// Ports   : i_rem    [STRB_W]  remaining strobe bits of the current beat
//           o_mask   [STRB_W]  selected chunk lanes (0 when i_rem is 0)
//           o_size   [SZ_W]    log2 of chunk size in bytes
//           o_offset [OFF_W]   lowest lane of the chunk
//           o_last             no strobe bits remain outside the chunk
// -----------------------------------------------------------------------------
module strb_chunk_sel
  import strb_split_pkg::*;
#(
  parameter  int STRB_W        = 8,
  parameter  int MAX_SIZE_LOG2 = clog2_f(STRB_W),
  localparam int OFF_W         = clog2_f(STRB_W),
  localparam int SZ_W          = (MAX_SIZE_LOG2 == 0) ? 1 : clog2_f(MAX_SIZE_LOG2 + 1)
) (
  input  logic [STRB_W-1:0] i_rem,
  output logic [STRB_W-1:0] o_mask,
  output logic [SZ_W-1:0]   o_size,
  output logic [OFF_W-1:0]  o_offset,
  output logic              o_last
);

  logic [OFF_W-1:0]       w_pos;
  logic [STRB_W-1:0]      w_shifted;
  logic [MAX_SIZE_LOG2:0] w_fit;
  logic [STRB_W-1:0]      w_low [MAX_SIZE_LOG2+1];
  logic [STRB_W-1:0]      w_sel_low;
  logic                   w_any;

  // Lowest-set-bit priority encoder: scanning downward lets the lowest lane win.
  always_comb begin
    w_pos = '0;
    for (int i = STRB_W - 1; i >= 0; i--) begin
      if (i_rem[i]) begin
        w_pos = OFF_W'(i);
      end
    end
  end

  assign w_any     = |i_rem;
  // Chunk candidates are tested against the strobe re-based at the start lane.
  assign w_shifted = i_rem >> w_pos;

  genvar gi;
  generate
    for (gi = 0; gi <= MAX_SIZE_LOG2; gi++) begin : g_size
      localparam int                LANES = size_to_bytes(gi);
      localparam logic [STRB_W-1:0] LOW   = {STRB_W{1'b1}} >> (STRB_W - LANES);
      localparam logic [OFF_W-1:0]  ALIGN = OFF_W'(LANES - 1);
      assign w_low[gi] = LOW;
      // Start lane must be aligned to the chunk size, and every lane covered.
      assign w_fit[gi] = ((w_pos & ALIGN) == '0) && ((w_shifted & LOW) == LOW);
    end
  endgenerate

  // Largest fitting size wins.
  always_comb begin
    o_size    = SZ_W'(SZ_1B);
    w_sel_low = w_low[0];
    for (int k = 0; k <= MAX_SIZE_LOG2; k++) begin
      if (w_fit[k]) begin
        o_size    = SZ_W'(k);
        w_sel_low = w_low[k];
      end
    end
  end

  assign o_mask   = w_any ? (w_sel_low << w_pos) : '0;
  assign o_offset = w_pos;
  assign o_last   = ((i_rem & ~o_mask) == '0);

endmodule

// File: rtl/strb_split_mask.sv
// -----------------------------------------------------------------------------
// strb_split_mask
// Purpose : splits one AXI write strobe per input handshake into a sequence of
//           naturally aligned power-of-two byte-lane masks, one per output
//           handshake, each usable directly as a P-Mesh store mask.
// Config  : `define STRB_SPLIT_ZERO_PASS_EN to emit a single all-zero chunk for
//           an all-zero strobe; otherwise such a beat is consumed silently.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           i_strb  [STRB_W]    AXI wstrb, bit i = byte lane i
//           i_valid / i_ready   input beat handshake
//           o_mask  [STRB_W]    aligned chunk mask
//           o_size  [SZ_W]      log2 chunk size in bytes
//           o_offset[OFF_W]     lowest byte lane of the chunk
//           o_first / o_last    first / final chunk of the beat
//           o_valid / o_ready   output chunk handshake
// -----------------------------------------------------------------------------
module strb_split_mask
  import strb_split_pkg::*;
#(
  parameter  int STRB_W        = 8,
  parameter  int MAX_SIZE_LOG2 = clog2_f(STRB_W),
  localparam int OFF_W         = clog2_f(STRB_W),
  localparam int SZ_W          = (MAX_SIZE_LOG2 == 0) ? 1 : clog2_f(MAX_SIZE_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STRB_W-1:0] i_strb,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [STRB_W-1:0] o_mask,
  output logic [SZ_W-1:0]   o_size,
  output logic [OFF_W-1:0]  o_offset,
  output logic              o_first,
  output logic              o_last,
  output logic              o_valid,
  input  logic              o_ready
);

  state_t            r_state;
  state_t            w_state_next;
  logic [STRB_W-1:0] r_rem;
  logic              r_first;

  logic [STRB_W-1:0] w_mask;
  logic [SZ_W-1:0]   w_size;
  logic [OFF_W-1:0]  w_offset;
  logic              w_last;
  logic              w_last_eff;
  logic              w_busy;
  logic              w_chunk_done;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load;

  strb_chunk_sel #(
    .STRB_W       (STRB_W),
    .MAX_SIZE_LOG2(MAX_SIZE_LOG2)
  ) u_chunk_sel (
    .i_rem   (r_rem),
    .o_mask  (w_mask),
    .o_size  (w_size),
    .o_offset(w_offset),
    .o_last  (w_last)
  );

  assign w_busy       = (r_state == BUSY);
  assign w_chunk_done = w_busy & o_ready;

`ifdef STRB_SPLIT_ZERO_PASS_EN
  // A zero beat sits in BUSY with r_rem == 0; the flag marks it as a real chunk.
  logic r_zero;
  assign w_last_eff = w_last | r_zero;
  assign w_load     = w_accept;
`else
  assign w_last_eff = w_last;
  assign w_load     = w_accept & (|i_strb);
`endif

  // A new beat may be taken on the same edge the last chunk leaves, so the
  // next beat's first chunk follows with no bubble. Held low during reset.
  assign w_in_ready = ~rst & (~w_busy | (w_chunk_done & w_last_eff));
  assign w_accept   = i_valid & w_in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_chunk_done & w_last_eff) begin
          w_state_next = w_load ? BUSY : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Remaining-strobe and first-chunk tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_first <= 1'b0;
    end else if (w_accept) begin
      r_rem   <= i_strb;
      r_first <= w_load;
    end else if (w_chunk_done) begin
      r_rem   <= r_rem & ~w_mask;
      r_first <= 1'b0;
    end
  end

`ifdef STRB_SPLIT_ZERO_PASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_zero <= ~|i_strb;
    end else if (w_chunk_done) begin
      r_zero <= 1'b0;
    end
  end
`endif

  // Output logic: everything downstream-facing is zero unless a chunk is valid.
  always_comb begin
    i_ready  = w_in_ready;
    o_valid  = 1'b0;
    o_mask   = '0;
    o_size   = '0;
    o_offset = '0;
    o_first  = 1'b0;
    o_last   = 1'b0;
    if (w_busy) begin
      o_valid  = 1'b1;
      o_mask   = w_mask;
      o_size   = w_size;
      o_offset = w_offset;
      o_first  = r_first;
      o_last   = w_last_eff;
    end
  end

endmodule
